plotter_pixel_feeder: RTL and testbench

Upstream stage of the pen-plotter datapath: streams a stored grayscale frame out of block RAM, thresholds each sample to one bit, and presents it to the plotter controller's `pixel_value_in`. It advances one pixel per `ready_next_pixel` rising edge, raster order (row-major, left to right). It also gates the plotter's `enable_plotter` so drawing only starts once the first valid pixel is on the wire.

---
 rtl/plotter_pkg.sv | 25 ++
 rtl/plotter_pixel_feeder.sv | 166 ++++++++++++++++
 tb/tb_plotter_pixel_feeder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/plotter_pkg.sv
// Shared definitions for the pen-plotter datapath.
//   feeder_state_t : state encoding of plotter_pixel_feeder
//   PIXEL_STEPS    : plotter steps drawn per image pixel
//   H_STEPS        : horizontal carriage travel in steps
//   V_STEPS        : vertical paper travel in steps
//   DEF_COLS/ROWS  : default frame geometry derived from the step counts
package plotter_pkg;

  localparam int unsigned PIXEL_STEPS = 9;
  localparam int unsigned H_STEPS     = 720;
  localparam int unsigned V_STEPS     = 960;

  // One column of margin keeps the last pixel's steps inside the carriage travel.
  localparam int unsigned DEF_COLS = H_STEPS / PIXEL_STEPS - 1;  // 79
  localparam int unsigned DEF_ROWS = V_STEPS / PIXEL_STEPS;      // 106

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_FLUSH,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/plotter_pixel_feeder.sv
// Streams a stored grayscale frame out of block RAM in raster order, thresholds
// each sample to one bit and presents it to the plotter controller.
// Ports:
//   clk_65mhz, rst     : system clock, synchronous active-high reset
//   start              : one-cycle pulse, begins a frame from IDLE or DONE
//   threshold, invert  : pixel = (sample < threshold) ^ invert
//   bram_addr/data     : frame BRAM read port, data valid RD_LAT cycles later
//   ready_next_pixel   : plotter level, rising edge consumes current pixel
//   drawing_done       : plotter level, frame finished
//   pixel_value        : thresholded bit to plotter
//   enable_plotter     : high once the first valid pixel is on the wire
//   busy               : high from accepted start until DONE
//   pixel_idx          : linear index of the presented pixel
module plotter_pixel_feeder
  import plotter_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = $clog2(COLS * ROWS),
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_65mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        threshold,
  input  logic              invert,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_data,
  input  logic              ready_next_pixel,
  input  logic              drawing_done,
  output logic              pixel_value,
  output logic              enable_plotter,
  output logic              busy,
  output logic [ADDR_W-1:0] pixel_idx
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [COL_W-1:0]  col_q,   col_d;
  logic [ROW_W-1:0]  row_q,   row_d;
  logic [LAT_W-1:0]  lat_q,   lat_d;
  logic              pix_q,   pix_d;
  logic              en_q,    en_d;
  logic              busy_q,  busy_d;
  logic              rdy_q,   rdy_d;

  logic rdy_rise;
  logic last_pixel;

  always_ff @(posedge clk_65mhz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      lat_q   <= '0;
      pix_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lat_q   <= lat_d;
      pix_q   <= pix_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy_rise   = ready_next_pixel & ~rdy_q;
  assign last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    lat_d   = lat_q;
    pix_d   = pix_q;
    en_d    = en_q;
    busy_d  = busy_q;
    rdy_d   = ready_next_pixel;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          lat_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (drawing_done) begin
          state_d = ST_DONE;
        end else if (lat_q == LAT_LAST) begin
          pix_d   = (bram_data < threshold) ^ invert;
          en_d    = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      ST_PRESENT: begin
        if (drawing_done) begin
          state_d = ST_DONE;
        end else if (rdy_rise) begin
          if (last_pixel) begin
            pix_d   = 1'b0;
            state_d = ST_FLUSH;
          end else begin
            // Linear address runs alongside col/row; col/row only find the frame end.
            addr_d = addr_q + 1'b1;
            lat_d  = '0;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            state_d = ST_FETCH;
          end
        end
      end

      ST_FLUSH: begin
        pix_d = 1'b0;
        if (drawing_done) begin
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Every path into DONE parks the pen and releases the plotter.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      busy_d = 1'b0;
      en_d   = 1'b0;
      pix_d  = 1'b0;
    end
  end

  assign bram_addr      = addr_q;
  assign pixel_idx      = addr_q;
  assign pixel_value    = pix_q;
  assign enable_plotter = en_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_plotter_pixel_feeder.sv
module tb_plotter_pixel_feeder;

  localparam int unsigned COLS   = 4;
  localparam int unsigned ROWS   = 2;
  localparam int unsigned NPIX   = COLS * ROWS;
  localparam int unsigned AW     = 3;
  localparam int unsigned RD_LAT = 2;

  logic          clk_65mhz = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    threshold = 8'd128;
  logic          invert = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_data;
  logic          ready_next_pixel = 1'b0;
  logic          drawing_done = 1'b0;
  logic          pixel_value;
  logic          enable_plotter;
  logic          busy;
  logic [AW-1:0] pixel_idx;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  mem [NPIX];
  logic [7:0]  rd_s1, rd_s2;
  int unsigned cur_idx;
  logic        exp_pix;

  plotter_pixel_feeder #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(AW),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk_65mhz       (clk_65mhz),
    .rst             (rst),
    .start           (start),
    .threshold       (threshold),
    .invert          (invert),
    .bram_addr       (bram_addr),
    .bram_data       (bram_data),
    .ready_next_pixel(ready_next_pixel),
    .drawing_done    (drawing_done),
    .pixel_value     (pixel_value),
    .enable_plotter  (enable_plotter),
    .busy            (busy),
    .pixel_idx       (pixel_idx)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  // Two-stage read pipeline: data for an address appears two clocks later.
  always @(posedge clk_65mhz) begin
    rd_s1 <= mem[bram_addr];
    rd_s2 <= rd_s1;
  end
  assign bram_data = rd_s2;

  function automatic logic model_bit(int unsigned idx);
    return (mem[idx] < threshold) ^ invert;
  endfunction

  task automatic tick();
    @(posedge clk_65mhz);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_addr"}, 32'(bram_addr), 0);
    check({tag, "_idx"}, 32'(pixel_idx), 0);
    check({tag, "_pix"}, 32'(pixel_value), 0);
    check({tag, "_en"}, 32'(enable_plotter), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < int'(NPIX); i++) mem[i] = 8'($urandom);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_en_early", 32'(enable_plotter), 0);
    tick();
    tick();
    check("start_en_lat2", 32'(enable_plotter), 0);
    tick();
    cur_idx = 0;
    exp_pix = model_bit(0);
    check("start_pix", 32'(pixel_value), 32'(exp_pix));
    check("start_en", 32'(enable_plotter), 1);
    check("start_addr", 32'(bram_addr), 0);
  endtask

  task automatic advance(int unsigned hold);
    cur_idx++;
    ready_next_pixel = 1'b1;
    tick();
    check("adv_addr", 32'(bram_addr), cur_idx);
    check("adv_idx", 32'(pixel_idx), cur_idx);
    check("adv_pix_kept", 32'(pixel_value), 32'(exp_pix));
    tick();
    tick();
    tick();
    exp_pix = model_bit(cur_idx);
    check("adv_pix_new", 32'(pixel_value), 32'(exp_pix));
    check("adv_en", 32'(enable_plotter), 1);
    repeat (hold) tick();
    check("adv_hold_addr", 32'(bram_addr), cur_idx);
    ready_next_pixel = 1'b0;
    tick();
  endtask

  task automatic last_edge_and_done();
    ready_next_pixel = 1'b1;
    tick();
    check("flush_pix", 32'(pixel_value), 0);
    check("flush_busy", 32'(busy), 1);
    check("flush_idx", 32'(pixel_idx), NPIX - 1);
    ready_next_pixel = 1'b0;
    repeat ($urandom_range(1, 6)) tick();
    check("flush_pix_hold", 32'(pixel_value), 0);
    check("flush_busy_hold", 32'(busy), 1);
    drawing_done = 1'b1;
    tick();
    drawing_done = 1'b0;
    check("done_busy", 32'(busy), 0);
    check("done_en", 32'(enable_plotter), 0);
    check("done_pix", 32'(pixel_value), 0);
  endtask

  initial begin
    randomize_mem();
    mem[0] = 8'd10;
    mem[1] = 8'd200;
    mem[2] = 8'd10;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle");

    // Frame with directed first pixels.
    threshold = 8'd128;
    invert = 1'b0;
    do_start();
    check("dir_pix0", 32'(pixel_value), 1);
    advance(46);
    check("dir_pix1", 32'(pixel_value), 0);
    check("dir_held_once", 32'(bram_addr), 1);
    invert = 1'b1;
    advance(0);
    check("dir_inv_pix2", 32'(pixel_value), 0);
    for (int i = 3; i < int'(NPIX); i++) begin
      threshold = 8'($urandom);
      invert = 1'($urandom);
      advance($urandom_range(0, 5));
    end
    check("dir_idx7", 32'(pixel_idx), 7);
    last_edge_and_done();

    // Start while in DONE, then reset mid-frame.
    randomize_mem();
    do_start();
    for (int i = 1; i <= 5; i++) begin
      threshold = 8'($urandom);
      invert = 1'($urandom);
      advance($urandom_range(0, 3));
    end
    check("pre_rst_idx", 32'(pixel_idx), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("after_rst_start_ignored_none", 32'(busy), 1);
    tick();
    tick();
    tick();
    check("restart_addr", 32'(bram_addr), 0);
    check("restart_pix", 32'(pixel_value), 32'(model_bit(0)));
    check("restart_en", 32'(enable_plotter), 1);
    cur_idx = 0;
    exp_pix = model_bit(0);

    // drawing_done while presenting ends the frame early.
    advance(1);
    drawing_done = 1'b1;
    tick();
    drawing_done = 1'b0;
    check("early_done_busy", 32'(busy), 0);
    check("early_done_en", 32'(enable_plotter), 0);
    check("early_done_pix", 32'(pixel_value), 0);
    ready_next_pixel = 1'b1;
    repeat (3) tick();
    ready_next_pixel = 1'b0;
    tick();
    check("done_ignores_ready", 32'(busy), 0);

    // Randomized full frames.
    for (int f = 0; f < 4; f++) begin
      randomize_mem();
      threshold = 8'($urandom);
      invert = 1'($urandom);
      repeat ($urandom_range(0, 4)) tick();
      do_start();
      for (int i = 1; i < int'(NPIX); i++) begin
        threshold = 8'($urandom);
        invert = 1'($urandom);
        advance($urandom_range(0, 8));
      end
      last_edge_and_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
